// File: rtl/clock_dist_sequencer.sv
// clock_dist_sequencer: PLL lock debounce, reset-release synchroniser and per-domain burst clock gating.
// Optional per-domain gated-cycle counters are built when CLOCK_DIST_CYCLE_COUNT_EN is defined.
module clock_dist_sequencer #(
    parameter int NUM_DOMAINS     = 4,
    parameter int RST_SYNC_STAGES = 3,
    parameter int LOCK_DEBOUNCE   = 64,
    parameter int CNT_W           = 16
) (
    input  logic                     root_clock,
    input  logic                     reset_n_trigger,
    input  logic                     pll_locked,
    output logic                     locked,
    output logic                     sync_rst_n,
    input  logic                     budget_valid,
    output logic                     budget_ready,
    input  logic [CNT_W-1:0]         budget_cycles,
    input  logic [NUM_DOMAINS-1:0]   budget_mask,
    output logic [NUM_DOMAINS-1:0]   gate_en,
    output logic                     done,
    output logic                     abort,
    output logic [32*NUM_DOMAINS-1:0] cycle_count
);
    localparam int DW = $clog2(LOCK_DEBOUNCE + 1);

    typedef enum logic [1:0] {S_WAIT_LOCK, S_SYNC, S_RUN} state_t;

    state_t                     state, state_nx;
    logic                       lk_m, lk_s;
    logic [DW-1:0]              dbc;
    logic [RST_SYNC_STAGES-1:0] sr, sr_nx;
    logic [CNT_W-1:0]           run_cnt;
    logic [NUM_DOMAINS-1:0]     mask_q;
    logic                       active;
    logic                       xfer;

    assign locked       = dbc == DW'(LOCK_DEBOUNCE);
    assign sync_rst_n   = sr[RST_SYNC_STAGES-1];
    assign budget_ready = (state == S_RUN) & locked & (run_cnt == '0) & ~active & ~done;
    assign xfer         = budget_valid & budget_ready;

    always_ff @(posedge root_clock or negedge reset_n_trigger) begin
        if (!reset_n_trigger) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
            dbc  <= '0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
            dbc  <= !lk_s ? '0 : locked ? dbc : dbc + 1'b1;
        end
    end

    // The shift register starts filling on the edge that leaves WAIT_LOCK, so RUN
    // is reached exactly RST_SYNC_STAGES edges after locked rises.
    always_comb begin
        sr_nx    = locked ? {sr[RST_SYNC_STAGES-2:0], 1'b1} : '0;
        state_nx = !locked ? S_WAIT_LOCK : sr_nx[RST_SYNC_STAGES-1] ? S_RUN : S_SYNC;
    end

    always_ff @(posedge root_clock or negedge reset_n_trigger) begin
        if (!reset_n_trigger) begin
            state <= S_WAIT_LOCK;
            sr    <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
        end
    end

    always_ff @(posedge root_clock or negedge reset_n_trigger) begin
        if (!reset_n_trigger) begin
            run_cnt <= '0;
            mask_q  <= '0;
            gate_en <= '0;
            active  <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
        end else if (!locked) begin
            run_cnt <= '0;
            gate_en <= '0;
            active  <= 1'b0;
            done    <= 1'b0;
            abort   <= active;
        end else begin
            abort   <= 1'b0;
            gate_en <= (run_cnt != '0) ? mask_q : '0;
            done    <= active & (run_cnt == '0);
            if (xfer) begin
                run_cnt <= budget_cycles;
                mask_q  <= budget_mask;
                active  <= 1'b1;
            end else if (run_cnt != '0) begin
                run_cnt <= run_cnt - 1'b1;
            end else if (active) begin
                active  <= 1'b0;
            end
        end
    end

`ifdef CLOCK_DIST_CYCLE_COUNT_EN
    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_cnt
        logic [31:0] c;
        always_ff @(posedge root_clock or negedge reset_n_trigger) begin
            if (!reset_n_trigger)
                c <= '0;
            else if (!sync_rst_n)
                c <= '0;
            else if (gate_en[i])
                c <= c + 1'b1;
        end
        assign cycle_count[32*i +: 32] = c;
    end
`else
    assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_clock_dist_sequencer.sv
// tb_clock_dist_sequencer: directed table-driven bench for clock_dist_sequencer (defaults, 4 domains).
// Expected counter values follow CLOCK_DIST_CYCLE_COUNT_EN when it is defined for the build.
module tb_clock_dist_sequencer;
    localparam int ND = 4;
    localparam int CW = 16;

    logic              root_clock = 1'b0;
    logic              reset_n_trigger = 1'b0;
    logic              pll_locked = 1'b0;
    logic              budget_valid = 1'b0;
    logic [CW-1:0]     budget_cycles = '0;
    logic [ND-1:0]     budget_mask = '0;
    logic              locked, sync_rst_n, budget_ready, done, abort;
    logic [ND-1:0]     gate_en;
    logic [32*ND-1:0]  cycle_count;

    int tests = 0;
    int fails = 0;
    int exp_cnt [ND];

    typedef struct {
        logic [CW-1:0] cyc;
        logic [ND-1:0] mask;
        logic [ND-1:0] gate;
        int            done_at;
        int            ready_at;
    } vec_t;
    vec_t vecs [5];

    clock_dist_sequencer dut (
        .root_clock(root_clock), .reset_n_trigger(reset_n_trigger), .pll_locked(pll_locked),
        .locked(locked), .sync_rst_n(sync_rst_n), .budget_valid(budget_valid),
        .budget_ready(budget_ready), .budget_cycles(budget_cycles), .budget_mask(budget_mask),
        .gate_en(gate_en), .done(done), .abort(abort), .cycle_count(cycle_count)
    );

    always #5 root_clock = ~root_clock;

    initial begin
        #200us;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge root_clock);
        @(negedge root_clock);
    endtask

    task automatic chk_counts();
        for (int d = 0; d < ND; d++) begin
`ifdef CLOCK_DIST_CYCLE_COUNT_EN
            chk("cycle_count", cycle_count[32*d +: 32], exp_cnt[d]);
`else
            chk("cycle_count", cycle_count[32*d +: 32], 0);
`endif
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!budget_ready && n < 300) begin
            step();
            n++;
        end
        chk("ready_wait", budget_ready, 1);
    endtask

    initial begin
        vecs[0] = '{16'd5, 4'b0101, 4'b0101, 6, 7};
        vecs[1] = '{16'd0, 4'b1111, 4'b0000, 1, 2};
        vecs[2] = '{16'd1, 4'b1000, 4'b1000, 2, 3};
        vecs[3] = '{16'd3, 4'b0000, 4'b0000, 4, 5};
        vecs[4] = '{16'd7, 4'b1111, 4'b1111, 8, 9};
        for (int d = 0; d < ND; d++) exp_cnt[d] = 0;

        repeat (3) step();
        chk("rst_locked", locked, 0);
        chk("rst_sync_rst_n", sync_rst_n, 0);
        chk("rst_ready", budget_ready, 0);
        chk("rst_gate", gate_en, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        chk_counts();

        // Lock-up with a request held high through WAIT_LOCK and SYNC
        reset_n_trigger = 1'b1;
        pll_locked = 1'b1;
        budget_valid = 1'b1;
        budget_cycles = 16'd2;
        budget_mask = 4'b0011;
        for (int e = 1; e <= 69; e++) begin
            step();
            if (e == 65) chk("locked_65", locked, 0);
            if (e == 66) chk("locked_66", locked, 1);
            if (e == 68) begin
                chk("sync_68", sync_rst_n, 0);
                chk("ready_68", budget_ready, 0);
                chk("gate_68", gate_en, 0);
            end
            if (e == 69) begin
                chk("sync_69", sync_rst_n, 1);
                chk("ready_69", budget_ready, 1);
            end
        end
        step();
        chk("held_ready_70", budget_ready, 0);
        chk("held_gate_70", gate_en, 0);
        budget_valid = 1'b0;
        step();
        chk("held_gate_71", gate_en, 4'b0011);
        step();
        chk("held_gate_72", gate_en, 4'b0011);
        chk("held_done_72", done, 0);
        step();
        chk("held_gate_73", gate_en, 0);
        chk("held_done_73", done, 1);
        step();
        chk("held_ready_74", budget_ready, 1);
        chk("held_done_74", done, 0);
        exp_cnt[0] += 2;
        exp_cnt[1] += 2;
        chk_counts();

        foreach (vecs[r]) begin
            wait_ready();
            budget_valid = 1'b1;
            budget_cycles = vecs[r].cyc;
            budget_mask = vecs[r].mask;
            step();
            budget_valid = 1'b0;
            chk("vec_ready_xfer", budget_ready, 0);
            for (int j = 1; j <= vecs[r].ready_at; j++) begin
                step();
                chk("vec_gate", gate_en, (j <= int'(vecs[r].cyc)) ? vecs[r].gate : 4'b0000);
                chk("vec_done", done, j == vecs[r].done_at);
                chk("vec_abort", abort, 0);
                if (j == vecs[r].ready_at) chk("vec_ready_again", budget_ready, 1);
            end
            for (int d = 0; d < ND; d++) if (vecs[r].mask[d]) exp_cnt[d] += int'(vecs[r].cyc);
            chk_counts();
        end

        // Lock loss in cycle 3 of a 100-cycle burst
        wait_ready();
        budget_valid = 1'b1;
        budget_cycles = 16'd100;
        budget_mask = 4'b1111;
        step();
        budget_valid = 1'b0;
        step();
        chk("ab_gate_k1", gate_en, 4'b1111);
        step();
        pll_locked = 1'b0;
        step();
        step();
        step();
        chk("ab_gate_k5", gate_en, 4'b1111);
        chk("ab_locked_k5", locked, 0);
        chk("ab_abort_k5", abort, 0);
        chk("ab_sync_k5", sync_rst_n, 1);
        step();
        chk("ab_gate_k6", gate_en, 0);
        chk("ab_abort_k6", abort, 1);
        chk("ab_done_k6", done, 0);
        chk("ab_sync_k6", sync_rst_n, 0);
        chk("ab_ready_k6", budget_ready, 0);
        step();
        chk("ab_abort_k7", abort, 0);
        for (int d = 0; d < ND; d++) exp_cnt[d] = 0;
        chk_counts();
        pll_locked = 1'b1;
        for (int e = 1; e <= 69; e++) begin
            step();
            if (e <= 5) chk("ab_no_done", done, 0);
            if (e == 65) chk("relock_65", locked, 0);
            if (e == 66) chk("relock_66", locked, 1);
            if (e == 68) chk("relock_ready_68", budget_ready, 0);
            if (e == 69) begin
                chk("relock_sync_69", sync_rst_n, 1);
                chk("relock_ready_69", budget_ready, 1);
            end
        end

        // Asynchronous reset in the middle of a burst
        budget_valid = 1'b1;
        budget_cycles = 16'd10;
        budget_mask = 4'b1010;
        step();
        budget_valid = 1'b0;
        step();
        step();
        chk("mr_gate_before", gate_en, 4'b1010);
        reset_n_trigger = 1'b0;
        #1;
        chk("mr_gate", gate_en, 0);
        chk("mr_sync", sync_rst_n, 0);
        chk("mr_locked", locked, 0);
        chk("mr_ready", budget_ready, 0);
        chk("mr_done", done, 0);
        chk("mr_abort", abort, 0);
        step();
        chk("mr_done_after", done, 0);
        chk("mr_abort_after", abort, 0);
        chk_counts();

        // One-cycle lock glitch at debounce count 40
        reset_n_trigger = 1'b1;
        for (int e = 1; e <= 109; e++) begin
            step();
            if (e == 42) pll_locked = 1'b0;
            if (e == 43) pll_locked = 1'b1;
            if (e == 66) chk("glitch_locked_66", locked, 0);
            if (e == 108) chk("glitch_locked_108", locked, 0);
            if (e == 109) chk("glitch_locked_109", locked, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
